// File: rtl/decode_issue_ctrl_pkg.sv
// Shared widths, default sizes and storage types for the decode/issue slice.
// Imported by decode_issue_ctrl and decode_scoreboard.
// Widths are the architecture values for instruction, PC and register address.
package decode_issue_ctrl_pkg;

  localparam int unsigned INST_W             = 32;
  localparam int unsigned PC_W               = 32;
  localparam int unsigned REG_ADDR_W         = 5;
  localparam int unsigned DECODE_QUEUE_DEPTH = 4;
  localparam int unsigned REG_COUNT_DEF      = 2 ** REG_ADDR_W;

  // One buffered fetch slot: the instruction and its next-PC travel together.
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   npc;
  } fetch_entry_t;

  // Register 0 is hard-wired and never tracked as in flight.
  function automatic logic is_tracked_reg(input logic [REG_ADDR_W-1:0] addr);
    return addr != '0;
  endfunction

endpackage

// File: rtl/decode_issue_ctrl_scoreboard.sv
// decode_scoreboard: busy vector of in-flight destination registers.
//   clk, rst            clock, asynchronous active-high reset
//   set_en/set_addr     mark a register busy at the next edge (issue of a writer)
//   clr_en/clr_addr     mark a register free at the next edge (writeback)
//   use_*/addr_*        three lookup ports (rs1, rs2, rd) for the decoder head
//   hazard              any used lookup register is busy
// Macro DECODE_CTRL_WB_BYPASS_EN: a register being cleared this cycle is
// already seen as free by the lookups.
module decode_scoreboard
  import decode_issue_ctrl_pkg::*;
#(
  parameter int unsigned REG_COUNT = REG_COUNT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  input  logic                  use_rs1,
  input  logic [REG_ADDR_W-1:0] addr_rs1,
  input  logic                  use_rs2,
  input  logic [REG_ADDR_W-1:0] addr_rs2,
  input  logic                  use_rd,
  input  logic [REG_ADDR_W-1:0] addr_rd,
  output logic                  hazard
);

  logic [REG_COUNT-1:0] busy_q;
  logic [REG_COUNT-1:0] busy_d;
  logic [REG_COUNT-1:0] busy_eff;

  // Clear is applied before set so a same-cycle set of the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en && is_tracked_reg(set_addr)) busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

`ifdef DECODE_CTRL_WB_BYPASS_EN
  always_comb begin
    busy_eff = busy_q;
    if (clr_en) busy_eff[clr_addr] = 1'b0;
  end
`else
  always_comb begin
    busy_eff = busy_q;
  end
`endif

  always_comb begin
    hazard = (use_rs1 && busy_eff[addr_rs1]) ||
             (use_rs2 && busy_eff[addr_rs2]) ||
             (use_rd  && busy_eff[addr_rd]);
  end

endmodule

// File: rtl/decode_issue_ctrl.sv
// decode_issue_ctrl: decode-stage sequencer between fetch and issue.
// Buffers fetched inst/npc pairs in a FIFO, presents the head to the external
// decoder, and raises iss_valid only when the decoded head has no register
// hazard against the scoreboard of in-flight destinations.
//   clk, rst                 clock, asynchronous active-high reset
//   f_valid/f_inst/f_npc     fetch offer; f_ready = FIFO not full
//   dec_inst/dec_npc         FIFO head to decoder (0 when empty)
//   dec_use_*/dec_rs*/dec_rd decoder register-use info for the head
//   iss_valid/iss_ready      issue handshake
//   wb_valid/wb_addr         writeback frees a destination register
//   flush                    empty the FIFO at the next edge
//   hazard_stall             head present but blocked by the scoreboard
//   q_count                  FIFO occupancy
// Macro DECODE_CTRL_WB_BYPASS_EN (in decode_scoreboard): writeback frees a
// register for hazard checking in the same cycle.
module decode_issue_ctrl
  import decode_issue_ctrl_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = DECODE_QUEUE_DEPTH,
  parameter int unsigned REG_COUNT   = REG_COUNT_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           f_valid,
  input  logic [INST_W-1:0]              f_inst,
  input  logic [PC_W-1:0]                f_npc,
  output logic                           f_ready,
  output logic [INST_W-1:0]              dec_inst,
  output logic [PC_W-1:0]                dec_npc,
  input  logic                           dec_use_rs1,
  input  logic                           dec_use_rs2,
  input  logic                           dec_use_rd,
  input  logic [REG_ADDR_W-1:0]          dec_rs1,
  input  logic [REG_ADDR_W-1:0]          dec_rs2,
  input  logic [REG_ADDR_W-1:0]          dec_rd,
  output logic                           iss_valid,
  input  logic                           iss_ready,
  input  logic                           wb_valid,
  input  logic [REG_ADDR_W-1:0]          wb_addr,
  input  logic                           flush,
  output logic                           hazard_stall,
  output logic [$clog2(QUEUE_DEPTH):0]   q_count
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [QUEUE_DEPTH];
  fetch_entry_t     mem_d [QUEUE_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic         empty;
  logic         full;
  logic         push;
  logic         pop;
  logic         hazard;
  logic         sb_set;
  fetch_entry_t head;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CNT_W'(QUEUE_DEPTH));
    f_ready = !full;
    head    = mem_q[rd_ptr_q];
    dec_inst = empty ? '0 : head.inst;
    dec_npc  = empty ? '0 : head.npc;
    iss_valid    = !empty && !hazard && !flush;
    hazard_stall = !empty && hazard;
    q_count      = count_q;
    // Flush suppresses both sides of the handshake for the cycle.
    push   = f_valid && f_ready && !flush;
    pop    = iss_valid && iss_ready;
    sb_set = pop && dec_use_rd && is_tracked_reg(dec_rd);
  end

  // Pointers rely on QUEUE_DEPTH being a power of two for natural wrap.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{inst: f_inst, npc: f_npc};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  decode_scoreboard #(
    .REG_COUNT (REG_COUNT)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (sb_set),
    .set_addr (dec_rd),
    .clr_en   (wb_valid),
    .clr_addr (wb_addr),
    .use_rs1  (dec_use_rs1),
    .addr_rs1 (dec_rs1),
    .use_rs2  (dec_use_rs2),
    .addr_rs2 (dec_rs2),
    .use_rd   (dec_use_rd),
    .addr_rd  (dec_rd),
    .hazard   (hazard)
  );

endmodule

// File: tb/tb_decode_issue_ctrl.sv
module tb_decode_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_valid;
  logic [31:0] f_inst;
  logic [31:0] f_npc;
  logic        f_ready;
  logic [31:0] dec_inst;
  logic [31:0] dec_npc;
  logic        dec_use_rs1, dec_use_rs2, dec_use_rd;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        iss_valid;
  logic        iss_ready;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic        flush;
  logic        hazard_stall;
  logic [2:0]  q_count;

  int n_checks = 0;
  int n_fail   = 0;

  decode_issue_ctrl #(
    .QUEUE_DEPTH (4),
    .REG_COUNT   (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .f_valid      (f_valid),
    .f_inst       (f_inst),
    .f_npc        (f_npc),
    .f_ready      (f_ready),
    .dec_inst     (dec_inst),
    .dec_npc      (dec_npc),
    .dec_use_rs1  (dec_use_rs1),
    .dec_use_rs2  (dec_use_rs2),
    .dec_use_rd   (dec_use_rd),
    .dec_rs1      (dec_rs1),
    .dec_rs2      (dec_rs2),
    .dec_rd       (dec_rd),
    .iss_valid    (iss_valid),
    .iss_ready    (iss_ready),
    .wb_valid     (wb_valid),
    .wb_addr      (wb_addr),
    .flush        (flush),
    .hazard_stall (hazard_stall),
    .q_count      (q_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic u1, input logic [4:0] r1, input logic u2,
                         input logic [4:0] r2, input logic ud, input logic [4:0] rd);
    dec_use_rs1 = u1; dec_rs1 = r1;
    dec_use_rs2 = u2; dec_rs2 = r2;
    dec_use_rd  = ud; dec_rd  = rd;
  endtask

  task automatic offer(input logic v, input logic [31:0] inst);
    f_valid = v;
    f_inst  = inst;
    f_npc   = inst + 32'h1000;
  endtask

  initial begin
    rst = 1'b1;
    offer(1'b0, 32'h0);
    set_dec(0, 0, 0, 0, 0, 0);
    iss_ready = 1'b0; wb_valid = 1'b0; wb_addr = '0; flush = 1'b0;
    #2;
    chk("rst_f_ready", f_ready, 1);
    chk("rst_iss_valid", iss_valid, 0);
    chk("rst_hazard", hazard_stall, 0);
    chk("rst_q_count", q_count, 0);
    chk("rst_dec_inst", dec_inst, 0);
    chk("rst_dec_npc", dec_npc, 0);
    tick();
    rst = 1'b0;

    // Fill to full with issue blocked; the 5th offer is held.
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, 32'h100 + 32'(i));
      tick();
    end
    offer(1'b1, 32'h104);
    #1;
    chk("full_q_count", q_count, 4);
    chk("full_f_ready", f_ready, 0);
    chk("full_head_inst", dec_inst, 32'h100);
    chk("full_head_npc", dec_npc, 32'h1100);
    chk("full_iss_valid", iss_valid, 1);
    tick();
    chk("held_q_count", q_count, 4);
    // Full: push+pop attempted, only the pop happens.
    iss_ready = 1'b1;
    tick();
    chk("full_pop_q_count", q_count, 3);
    chk("full_pop_head", dec_inst, 32'h101);
    chk("fifth_now_ready", f_ready, 1);
    tick(); // push 0x104, pop 0x101
    chk("pushpop_q_count", q_count, 3);
    chk("pushpop_head", dec_inst, 32'h102);
    for (int i = 0; i < 3; i++) begin
      offer(1'b1, 32'h105 + 32'(i));
      tick();
    end
    offer(1'b0, 32'h0);
    #1;
    chk("wrap_q_count", q_count, 3);
    chk("wrap_head", dec_inst, 32'h105);
    tick();
    chk("wrap_head2", dec_inst, 32'h106);
    tick();
    chk("wrap_head3", dec_inst, 32'h107);
    chk("wrap_npc3", dec_npc, 32'h1107);
    tick();
    chk("drain_q_count", q_count, 0);
    chk("drain_dec_inst", dec_inst, 0);
    chk("drain_iss_valid", iss_valid, 0);
    tick();
    chk("empty_pop_q_count", q_count, 0);

    // RAW hazard on r5 and its release by writeback.
    iss_ready = 1'b0;
    offer(1'b1, 32'h10);
    tick();
    offer(1'b1, 32'h11);
    iss_ready = 1'b1;
    set_dec(0, 0, 0, 0, 1, 5);
    #1;
    chk("latency_iss_valid", iss_valid, 1);
    tick();
    offer(1'b0, 32'h0);
    set_dec(1, 5, 0, 0, 0, 0);
    #1;
    chk("raw_head", dec_inst, 32'h11);
    chk("raw_stall", hazard_stall, 1);
    chk("raw_iss_valid", iss_valid, 0);
    tick();
    chk("raw_still_stall", hazard_stall, 1);
    wb_valid = 1'b1; wb_addr = 5'd5;
    #1;
`ifdef DECODE_CTRL_WB_BYPASS_EN
    chk("wb_cycle_iss_valid", iss_valid, 1);
    chk("wb_cycle_stall", hazard_stall, 0);
`else
    chk("wb_cycle_iss_valid", iss_valid, 0);
    chk("wb_cycle_stall", hazard_stall, 1);
`endif
    tick();
    wb_valid = 1'b0;
    #1;
`ifdef DECODE_CTRL_WB_BYPASS_EN
    chk("wb_issued_q_count", q_count, 0);
`else
    chk("after_wb_iss_valid", iss_valid, 1);
    tick();
    chk("wb_issued_q_count", q_count, 0);
`endif

    // rd=0 is never marked busy.
    iss_ready = 1'b0;
    offer(1'b1, 32'h20);
    tick();
    offer(1'b1, 32'h21);
    tick();
    offer(1'b0, 32'h0);
    iss_ready = 1'b1;
    set_dec(0, 0, 0, 0, 1, 0);
    #1;
    chk("rd0_iss_valid", iss_valid, 1);
    tick();
    set_dec(1, 0, 0, 0, 0, 0);
    #1;
    chk("rs0_iss_valid", iss_valid, 1);
    chk("rs0_stall", hazard_stall, 0);
    tick();
    chk("rd0_q_count", q_count, 0);

    // Flush empties the queue but leaves r7 busy.
    iss_ready = 1'b0;
    set_dec(0, 0, 0, 0, 0, 0);
    offer(1'b1, 32'h30);
    tick();
    iss_ready = 1'b1;
    set_dec(0, 0, 0, 0, 1, 7);
    offer(1'b1, 32'h31);
    tick();
    iss_ready = 1'b0;
    set_dec(0, 0, 0, 0, 0, 0);
    offer(1'b1, 32'h32);
    tick();
    offer(1'b1, 32'h33);
    tick();
    offer(1'b1, 32'h99);
    flush = 1'b1;
    #1;
    chk("preflush_q_count", q_count, 3);
    chk("flush_iss_valid", iss_valid, 0);
    tick();
    flush = 1'b0;
    offer(1'b0, 32'h0);
    #1;
    chk("flush_q_count", q_count, 0);
    chk("flush_dec_inst", dec_inst, 0);
    offer(1'b1, 32'h40);
    tick();
    offer(1'b0, 32'h0);
    set_dec(1, 7, 0, 0, 0, 0);
    #1;
    chk("flush_keeps_busy7", hazard_stall, 1);
    wb_valid = 1'b1; wb_addr = 5'd7;
    tick();
    wb_valid = 1'b0;
    #1;
    chk("busy7_cleared", iss_valid, 1);
    chk("busy7_stall", hazard_stall, 0);
    iss_ready = 1'b1;
    tick();
    chk("busy7_q_count", q_count, 0);

    // Same-cycle set and clear of r9: set wins.
    iss_ready = 1'b0;
    offer(1'b1, 32'h50);
    tick();
    iss_ready = 1'b1;
    set_dec(0, 0, 0, 0, 1, 9);
    wb_valid = 1'b1; wb_addr = 5'd9;
    offer(1'b1, 32'h51);
    tick();
    wb_valid = 1'b0;
    iss_ready = 1'b0;
    offer(1'b0, 32'h0);
    set_dec(1, 9, 0, 0, 0, 0);
    #1;
    chk("setwins_head", dec_inst, 32'h51);
    chk("setwins_stall", hazard_stall, 1);

    // Asynchronous reset mid-burst.
    offer(1'b1, 32'h60);
    tick();
    offer(1'b1, 32'h61);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_q_count", q_count, 0);
    chk("arst_f_ready", f_ready, 1);
    chk("arst_iss_valid", iss_valid, 0);
    chk("arst_stall", hazard_stall, 0);
    chk("arst_dec_inst", dec_inst, 0);
    chk("arst_dec_npc", dec_npc, 0);
    offer(1'b0, 32'h0);
    #1;
    rst = 1'b0;
    offer(1'b1, 32'h70);
    tick();
    offer(1'b0, 32'h0);
    #1;
    chk("arst_busy9_cleared", hazard_stall, 0);
    chk("arst_new_iss_valid", iss_valid, 1);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
